proc_control_unit: RTL and testbench
====================================

Name: proc_control_unit

Overview:
- Multi-cycle control unit of the simple 9-bit processor.
- Sits directly downstream of the PC counter. Latches the instruction word that the memory returns at the current PC, then sequences it over time steps T0..T3.
- Drives the register-file, ALU and bus-mux enables, asserts Done at instruction end, and pulses PCinc so the upstream PC counter advances.
- Holds its own step state, IR register and halt state.

Parameters:
- UNDEF_AS_NOP, default 1. 1 = an undefined opcode completes as a no-op in T1. 0 = an undefined opcode enters HALT.

Ports:
- MClock, input, 1: clock, rising edge.
- Resetn, input, 1: synchronous, active-low reset.
- Run, input, 1: start-instruction request, sampled only in T0.
- DIN, input, 9: memory data at the current PC (instruction or immediate).
- IR, output, 9: instruction register.
- Step, output, 2: current step (T0=0, T1=1, T2=2, T3=3; HALT reads 0).
- Halted, output, 1: high while in HALT.
- IRin, output, 1: IR load enable (for observation).
- PCinc, output, 1: one-cycle pulse that advances the PC counter.
- Rin, output, 8: one-hot register write enables.
- Rout, output, 8: one-hot register bus drives.
- Ain, output, 1: A register load.
- Gin, output, 1: G register load.
- Gout, output, 1: G drives bus.
- DINout, output, 1: DIN drives bus.
- AddSub, output, 1: ALU operation, 0 = add, 1 = sub.
- Done, output, 1: instruction complete.

Behaviour:
- Instruction format: IR[8:6] opcode, X = IR[5:3], Y = IR[2:0].
- Opcodes: 000 mv Rx,Ry; 001 mvi Rx,#D (immediate is the next memory word); 010 add Rx,Ry; 011 sub Rx,Ry; 100..111 undefined.
- State register: T0, T1, T2, T3, HALT. IR is the only other register.
- All control outputs are combinational decodes of state and IR. IRin and PCinc in T0 additionally depend on Run.
- Every output not listed for a step is 0. Rin and Rout are one-hot or zero, never multi-hot.
- T0 (idle/fetch):
  - Run=1: IRin=1, PCinc=1; at the edge IR<=DIN, next state T1.
  - Run=0: all outputs 0, stay in T0.
- T1:
  - mv: Rout[Y]=1, Rin[X]=1, Done=1 -> T0.
  - mvi: DINout=1, Rin[X]=1, PCinc=1, Done=1 -> T0. PCinc steps the PC past the immediate.
  - add/sub: Rout[X]=1, Ain=1 -> T2.
  - undefined with UNDEF_AS_NOP=1: Done=1 -> T0.
  - undefined with UNDEF_AS_NOP=0: no Done -> HALT.
- T2 (add/sub only): Rout[Y]=1, Gin=1, AddSub=IR[6] -> T3.
- T3 (add/sub only): Gout=1, Rin[X]=1, Done=1 -> T0.
- HALT: all enables 0, Halted=1. Exits only via reset.
- Latency in cycles from the Run-sampled edge to the Done cycle: mv/mvi 1; add/sub 3; undefined nop 1.
- Run is ignored outside T0. Run held high in T0 back-to-back starts the next fetch in the cycle right after Done.
- IR holds its value from the fetch edge until the next fetch. IR is not loaded outside T0.
- X = Y is legal: mv R3,R3 gives Rout[3]=Rin[3]=1.
- Reset (Resetn=0 at a rising edge) in any state, including mid-instruction and HALT:
  - next state T0, IR=9'h000, Halted=0.
  - No Done and no PCinc are generated for the aborted instruction.
  - After the reset edge all outputs are 0 until Run is sampled.
  - Reset has priority over Run.
- After reset-release, a Run sampled at the first edge is accepted normally.

Test Plan:
- Reset, then Run=1 with DIN=9'h015 (mv R2,R5) -> T0: IRin=1, PCinc=1; next cycle: IR=9'h015, Step=1, Rout=8'h20, Rin=8'h04, Done=1; then Step=0.
- DIN=9'h048 (mvi R1) fetched, DIN=9'h1A3 in T1 -> T1: DINout=1, Rin=8'h02, PCinc=1, Done=1. PCinc is high for exactly 2 cycles total.
- DIN=9'h09C (add R3,R4) -> T1: Rout=8'h08, Ain=1; T2: Rout=8'h10, Gin=1, AddSub=0; T3: Gout=1, Rin=8'h08, Done=1. DIN=9'h0C7 (sub R0,R7) -> T2: Rout=8'h80, AddSub=1.
- Undefined opcode DIN=9'h1C0 -> UNDEF_AS_NOP=1: Done=1 in T1, back to T0. UNDEF_AS_NOP=0: Halted=1, Step=0, Run pulses ignored for 10 cycles, Resetn=0 clears Halted.
- Resetn=0 during T2 of an add -> next cycle Step=0, IR=9'h000, all outputs 0, no Done; a subsequent Run fetches normally.
- Run held high over 3 back-to-back mv instructions -> Done on every second cycle, IRin in the alternating cycles, no missed or doubled fetch.

Source files
------------

// File: rtl/proc_control_unit_if.sv
// Bus bundle between the control unit and the datapath it steers: Run/DIN come in,
// the IR, step status and all register/ALU/bus-mux enables go out.
interface proc_control_unit_if;
    logic       Run;
    logic [8:0] DIN;
    logic [8:0] IR;
    logic [1:0] Step;
    logic       Halted;
    logic       IRin;
    logic       PCinc;
    logic [7:0] Rin;
    logic [7:0] Rout;
    logic       Ain;
    logic       Gin;
    logic       Gout;
    logic       DINout;
    logic       AddSub;
    logic       Done;

    modport master (
        output Run, DIN,
        input  IR, Step, Halted, IRin, PCinc, Rin, Rout,
        input  Ain, Gin, Gout, DINout, AddSub, Done
    );

    modport slave (
        input  Run, DIN,
        output IR, Step, Halted, IRin, PCinc, Rin, Rout,
        output Ain, Gin, Gout, DINout, AddSub, Done
    );
endinterface

// File: rtl/proc_control_unit.sv
// Multi-cycle control unit of the 9-bit processor: latches the instruction from DIN
// and sequences mv/mvi/add/sub over steps T0..T3, with an optional HALT on bad opcodes.
module proc_control_unit #(
    parameter bit UNDEF_AS_NOP = 1'b1
) (
    input  logic                 MClock,
    input  logic                 Resetn,
    proc_control_unit_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    state_t     state_q, state_d;
    logic [8:0] ir_q, ir_d;

    logic [2:0] opcode;
    logic [7:0] x_onehot, y_onehot;

    logic [1:0] step;
    logic       halted, irin, pcinc, ain, gin, gout, dinout, addsub, done;
    logic [7:0] rin, rout;

    assign opcode   = ir_q[8:6];
    assign x_onehot = 8'b0000_0001 << ir_q[5:3];
    assign y_onehot = 8'b0000_0001 << ir_q[2:0];

    // Reset wins over everything, including HALT and a Run sampled in T0.
    always_ff @(posedge MClock) begin
        if (!Resetn) begin
            state_q <= ST_T0;
            ir_q    <= 9'h000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            ST_T0: begin
                if (bus.Run) begin
                    ir_d    = bus.DIN;
                    state_d = ST_T1;
                end
            end
            ST_T1: begin
                case (opcode)
                    OP_MV, OP_MVI:  state_d = ST_T0;
                    OP_ADD, OP_SUB: state_d = ST_T2;
                    default:        state_d = UNDEF_AS_NOP ? ST_T0 : ST_HALT;
                endcase
            end
            ST_T2:   state_d = ST_T3;
            ST_T3:   state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_T0;
        endcase
    end

    always_comb begin
        step   = 2'd0;
        halted = 1'b0;
        irin   = 1'b0;
        pcinc  = 1'b0;
        rin    = 8'h00;
        rout   = 8'h00;
        ain    = 1'b0;
        gin    = 1'b0;
        gout   = 1'b0;
        dinout = 1'b0;
        addsub = 1'b0;
        done   = 1'b0;
        case (state_q)
            ST_T0: begin
                irin  = bus.Run;
                pcinc = bus.Run;
            end
            ST_T1: begin
                step = 2'd1;
                case (opcode)
                    OP_MV: begin
                        rout = y_onehot;
                        rin  = x_onehot;
                        done = 1'b1;
                    end
                    // The extra PCinc skips the immediate word so the next fetch sees an opcode.
                    OP_MVI: begin
                        dinout = 1'b1;
                        rin    = x_onehot;
                        pcinc  = 1'b1;
                        done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout = x_onehot;
                        ain  = 1'b1;
                    end
                    default: done = UNDEF_AS_NOP;
                endcase
            end
            ST_T2: begin
                step   = 2'd2;
                rout   = y_onehot;
                gin    = 1'b1;
                addsub = ir_q[6];
            end
            ST_T3: begin
                step = 2'd3;
                gout = 1'b1;
                rin  = x_onehot;
                done = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.IR     = ir_q;
    assign bus.Step   = step;
    assign bus.Halted = halted;
    assign bus.IRin   = irin;
    assign bus.PCinc  = pcinc;
    assign bus.Rin    = rin;
    assign bus.Rout   = rout;
    assign bus.Ain    = ain;
    assign bus.Gin    = gin;
    assign bus.Gout   = gout;
    assign bus.DINout = dinout;
    assign bus.AddSub = addsub;
    assign bus.Done   = done;

endmodule

// File: tb/tb_proc_control_unit.sv
// Scoreboard bench for proc_control_unit: two instances (undefined-as-nop and undefined-halts)
// share clock, reset and DIN; each cycle's expected outputs are queued and checked at negedge.
module tb_proc_control_unit;

    typedef struct packed {
        logic [8:0] ir;
        logic [1:0] step;
        logic [2:0] hip;
        logic [7:0] rin;
        logic [7:0] rout;
        logic [5:0] flags;
    } out_t;

    localparam logic [2:0] H  = 3'b100;
    localparam logic [2:0] FP = 3'b011;
    localparam logic [2:0] P  = 3'b001;
    localparam logic [5:0] AIN    = 6'b100000;
    localparam logic [5:0] GIN    = 6'b010000;
    localparam logic [5:0] GOUT   = 6'b001000;
    localparam logic [5:0] DINOUT = 6'b000100;
    localparam logic [5:0] ADDSUB = 6'b000010;
    localparam logic [5:0] DONE   = 6'b000001;

    logic MClock;
    logic Resetn;

    proc_control_unit_if bus_a ();
    proc_control_unit_if bus_b ();

    proc_control_unit #(.UNDEF_AS_NOP(1'b1)) dut_nop (
        .MClock (MClock),
        .Resetn (Resetn),
        .bus    (bus_a)
    );

    proc_control_unit #(.UNDEF_AS_NOP(1'b0)) dut_halt (
        .MClock (MClock),
        .Resetn (Resetn),
        .bus    (bus_b)
    );

    initial MClock = 1'b0;
    always #5 MClock = ~MClock;

    out_t  exp_a_q[$];
    out_t  exp_b_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    out_t act_a, act_b;
    assign act_a = {bus_a.IR, bus_a.Step, bus_a.Halted, bus_a.IRin, bus_a.PCinc, bus_a.Rin, bus_a.Rout,
                    bus_a.Ain, bus_a.Gin, bus_a.Gout, bus_a.DINout, bus_a.AddSub, bus_a.Done};
    assign act_b = {bus_b.IR, bus_b.Step, bus_b.Halted, bus_b.IRin, bus_b.PCinc, bus_b.Rin, bus_b.Rout,
                    bus_b.Ain, bus_b.Gin, bus_b.Gout, bus_b.DINout, bus_b.AddSub, bus_b.Done};

    function automatic out_t mk(input logic [8:0] ir, input logic [1:0] st, input logic [2:0] hip,
                                input logic [7:0] rin, input logic [7:0] rout, input logic [5:0] flags);
        return {ir, st, hip, rin, rout, flags};
    endfunction

    function automatic out_t idle(input logic [8:0] ir);
        return mk(ir, 2'd0, 3'b000, 8'h00, 8'h00, 6'b0);
    endfunction

    function automatic out_t fetch(input logic [8:0] ir);
        return mk(ir, 2'd0, FP, 8'h00, 8'h00, 6'b0);
    endfunction

    function automatic out_t hlt(input logic [8:0] ir);
        return mk(ir, 2'd0, H, 8'h00, 8'h00, 6'b0);
    endfunction

    task automatic checkOutput(input string nm, input string which, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s/%s: got ir=%h step=%0d hip=%b rin=%h rout=%h flags=%b, expected ir=%h step=%0d hip=%b rin=%h rout=%h flags=%b",
                     nm, which, act.ir, act.step, act.hip, act.rin, act.rout, act.flags,
                     exp.ir, exp.step, exp.hip, exp.rin, exp.rout, exp.flags);
        end
    endtask

    // Inputs change just after the rising edge; the expectation describes the cycle that follows.
    task automatic applyStimulus(input logic rn, input logic ra, input logic rb, input logic [8:0] d,
                                 input out_t ea, input out_t eb, input string nm);
        @(posedge MClock);
        #1;
        Resetn    = rn;
        bus_a.Run = ra;
        bus_b.Run = rb;
        bus_a.DIN = d;
        bus_b.DIN = d;
        exp_a_q.push_back(ea);
        exp_b_q.push_back(eb);
        name_q.push_back(nm);
    endtask

    always @(negedge MClock) begin
        if (exp_a_q.size() > 0) begin
            out_t  ea, eb;
            string nm;
            ea = exp_a_q.pop_front();
            eb = exp_b_q.pop_front();
            nm = name_q.pop_front();
            checkOutput(nm, "nop", act_a, ea);
            checkOutput(nm, "halt", act_b, eb);
        end
    end

    initial begin
        Resetn    = 1'b0;
        bus_a.Run = 1'b0;
        bus_b.Run = 1'b0;
        bus_a.DIN = 9'h000;
        bus_b.DIN = 9'h000;
        repeat (2) @(posedge MClock);

        applyStimulus(1, 0, 0, 9'h000, idle(9'h000), idle(9'h000), "reset_idle");

        // mv R2,R5
        applyStimulus(1, 1, 0, 9'h015, fetch(9'h000), idle(9'h000), "mv_fetch");
        applyStimulus(1, 0, 0, 9'h000, mk(9'h015, 2'd1, 3'b000, 8'h04, 8'h20, DONE), idle(9'h000), "mv_t1");
        applyStimulus(1, 0, 0, 9'h000, idle(9'h015), idle(9'h000), "mv_back_t0");

        // mvi R1,#0x1A3
        applyStimulus(1, 1, 0, 9'h048, fetch(9'h015), idle(9'h000), "mvi_fetch");
        applyStimulus(1, 0, 0, 9'h1A3, mk(9'h048, 2'd1, P, 8'h02, 8'h00, DINOUT | DONE), idle(9'h000), "mvi_t1");
        applyStimulus(1, 0, 0, 9'h000, idle(9'h048), idle(9'h000), "mvi_back_t0");

        // add R3,R4 with Run held high outside T0
        applyStimulus(1, 1, 0, 9'h09C, fetch(9'h048), idle(9'h000), "add_fetch");
        applyStimulus(1, 1, 0, 9'h000, mk(9'h09C, 2'd1, 3'b000, 8'h00, 8'h08, AIN), idle(9'h000), "add_t1");
        applyStimulus(1, 1, 0, 9'h000, mk(9'h09C, 2'd2, 3'b000, 8'h00, 8'h10, GIN), idle(9'h000), "add_t2");
        applyStimulus(1, 0, 0, 9'h000, mk(9'h09C, 2'd3, 3'b000, 8'h08, 8'h00, GOUT | DONE), idle(9'h000), "add_t3");
        applyStimulus(1, 0, 0, 9'h000, idle(9'h09C), idle(9'h000), "add_back_t0");

        // sub R0,R7
        applyStimulus(1, 1, 0, 9'h0C7, fetch(9'h09C), idle(9'h000), "sub_fetch");
        applyStimulus(1, 0, 0, 9'h000, mk(9'h0C7, 2'd1, 3'b000, 8'h00, 8'h01, AIN), idle(9'h000), "sub_t1");
        applyStimulus(1, 0, 0, 9'h000, mk(9'h0C7, 2'd2, 3'b000, 8'h00, 8'h80, GIN | ADDSUB), idle(9'h000), "sub_t2");
        applyStimulus(1, 0, 0, 9'h000, mk(9'h0C7, 2'd3, 3'b000, 8'h01, 8'h00, GOUT | DONE), idle(9'h000), "sub_t3");
        applyStimulus(1, 0, 0, 9'h000, idle(9'h0C7), idle(9'h000), "sub_back_t0");

        // Back-to-back mv R3,R3 / mv R1,R6 / mv R7,R0 with Run held high
        applyStimulus(1, 1, 0, 9'h01B, fetch(9'h0C7), idle(9'h000), "b2b_fetch0");
        applyStimulus(1, 1, 0, 9'h00E, mk(9'h01B, 2'd1, 3'b000, 8'h08, 8'h08, DONE), idle(9'h000), "b2b_t1_0");
        applyStimulus(1, 1, 0, 9'h00E, fetch(9'h01B), idle(9'h000), "b2b_fetch1");
        applyStimulus(1, 1, 0, 9'h038, mk(9'h00E, 2'd1, 3'b000, 8'h02, 8'h40, DONE), idle(9'h000), "b2b_t1_1");
        applyStimulus(1, 1, 0, 9'h038, fetch(9'h00E), idle(9'h000), "b2b_fetch2");
        applyStimulus(1, 0, 0, 9'h000, mk(9'h038, 2'd1, 3'b000, 8'h80, 8'h01, DONE), idle(9'h000), "b2b_t1_2");
        applyStimulus(1, 0, 0, 9'h000, idle(9'h038), idle(9'h000), "b2b_back_t0");

        // Reset in T2 of an add aborts without Done, then a fresh fetch works
        applyStimulus(1, 1, 0, 9'h09C, fetch(9'h038), idle(9'h000), "abort_fetch");
        applyStimulus(1, 0, 0, 9'h000, mk(9'h09C, 2'd1, 3'b000, 8'h00, 8'h08, AIN), idle(9'h000), "abort_t1");
        applyStimulus(0, 1, 0, 9'h015, mk(9'h09C, 2'd2, 3'b000, 8'h00, 8'h10, GIN), idle(9'h000), "abort_t2_reset");
        applyStimulus(1, 0, 0, 9'h000, idle(9'h000), idle(9'h000), "abort_cleared");
        applyStimulus(1, 1, 0, 9'h015, fetch(9'h000), idle(9'h000), "refetch");
        applyStimulus(1, 0, 0, 9'h000, mk(9'h015, 2'd1, 3'b000, 8'h04, 8'h20, DONE), idle(9'h000), "refetch_t1");
        applyStimulus(1, 0, 0, 9'h000, idle(9'h015), idle(9'h000), "refetch_t0");

        // Undefined opcode: nop instance completes, halt instance parks in HALT
        applyStimulus(1, 1, 1, 9'h1C0, fetch(9'h015), fetch(9'h000), "undef_fetch");
        applyStimulus(1, 0, 0, 9'h000, mk(9'h1C0, 2'd1, 3'b000, 8'h00, 8'h00, DONE),
                      mk(9'h1C0, 2'd1, 3'b000, 8'h00, 8'h00, 6'b0), "undef_t1");
        applyStimulus(1, 0, 0, 9'h015, idle(9'h1C0), hlt(9'h1C0), "undef_after");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, logic'(i % 2 == 0), 9'h015, idle(9'h1C0), hlt(9'h1C0), "halt_ignores_run");
        end
        applyStimulus(0, 0, 1, 9'h015, idle(9'h1C0), hlt(9'h1C0), "halt_reset");
        applyStimulus(1, 0, 1, 9'h015, idle(9'h000), fetch(9'h000), "halt_cleared_fetch");
        applyStimulus(1, 0, 0, 9'h000, idle(9'h000), mk(9'h015, 2'd1, 3'b000, 8'h04, 8'h20, DONE), "halt_cleared_t1");
        applyStimulus(1, 0, 0, 9'h000, idle(9'h000), idle(9'h015), "final_idle");

        repeat (3) @(posedge MClock);
        if (exp_a_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_a_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
